// File: rtl/pong_pkg.sv
// Shared constants and types for the pong renderer.
// Score-label placement, colon/net geometry, blink FSM encoding and hit bundle.
package pong_pkg;

    localparam logic [7:0] P_DIGIT_X  = 8'd74;
    localparam logic [7:0] C_DIGIT_X  = 8'd82;
    localparam logic [7:0] DIGIT_Y    = 8'd10;
    localparam logic [7:0] DIGIT_W    = 8'd3;
    localparam logic [7:0] DIGIT_H    = 8'd5;

    localparam logic [7:0] COLON_X    = 8'd79;
    localparam logic [7:0] COLON_Y0   = 8'd11;
    localparam logic [7:0] COLON_Y1   = 8'd13;

    localparam logic [7:0] NET_X      = 8'd80;
    localparam logic [7:0] NET_GAP_LO = 8'd10;
    localparam logic [7:0] NET_GAP_HI = 8'd14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BLINK_P = 2'd1,
        BLINK_C = 2'd2
    } blink_state_t;

    typedef struct packed {
        logic ball;
        logic player;
        logic com;
        logic pdig;
        logic cdig;
    } hit_t;

    typedef enum logic [2:0] {
        OBJ_NONE   = 3'd0,
        OBJ_BALL   = 3'd1,
        OBJ_PLAYER = 3'd2,
        OBJ_COM    = 3'd3,
        OBJ_PDIG   = 3'd4,
        OBJ_CDIG   = 3'd5,
        OBJ_COLON  = 3'd6,
        OBJ_NET    = 3'd7
    } obj_t;

    // lo <= v < lo+len, with the end computed in 9 bits so it never wraps
    function automatic logic in_span(
        input logic [7:0] v,
        input logic [7:0] lo,
        input logic [7:0] len
    );
        return (v >= lo) &&
               ({1'b0, v} < ({1'b0, lo} + {1'b0, len}));
    endfunction

endpackage

// File: rtl/digit_font.sv
// 3x5 glyph ROM for the score digits 0-9.
// Glyph index is 3*row+col, row 0 on top; digits 10-15 are blank.
module digit_font (
    input  logic [3:0] digit,
    input  logic [3:0] idx,
    output logic       pixel
);

    logic [14:0] mask;

    // Rows packed top-first, leftmost column in the row's MSB
    always_comb begin
        mask = '0;
        case (digit)
            4'd0:    mask = 15'b111_101_101_101_111;
            4'd1:    mask = 15'b010_110_010_010_111;
            4'd2:    mask = 15'b111_001_111_100_111;
            4'd3:    mask = 15'b111_001_111_001_111;
            4'd4:    mask = 15'b101_101_111_001_001;
            4'd5:    mask = 15'b111_100_111_001_111;
            4'd6:    mask = 15'b111_100_111_101_111;
            4'd7:    mask = 15'b111_001_001_001_001;
            4'd8:    mask = 15'b111_101_111_101_111;
            4'd9:    mask = 15'b111_101_111_001_111;
            default: mask = '0;
        endcase
    end

    // Index 0 is the top-left cell, which sits in the mask MSB
    always_comb begin
        pixel = 1'b0;
        if (idx < 4'd15)
            pixel = mask[4'd14 - idx];
    end

endmodule

// File: rtl/pong_renderer.sv
// Two-stage pixel renderer for a pong playfield with per-frame shadowed
// positions, score glyphs and a blink effect on the side that just scored.
module pong_renderer
    import pong_pkg::*;
#(
    parameter int BLOCK_SHIFT  = 2,
    parameter int BALL_SIZE    = 4,
    parameter int PADDLE_LEN   = 32,
    parameter int COLOR_W      = 8,
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_HALF   = 8
) (
    input  logic               CLK_IN,
    input  logic               RST_IN,
    input  logic               frame_start,
    input  logic               de_in,
    input  logic [9:0]         xCoord,
    input  logic [9:0]         yCoord,
    input  logic [7:0]         ballX,
    input  logic [6:0]         ballY,
    input  logic [7:0]         playerXPos,
    input  logic [6:0]         playerYPos,
    input  logic [7:0]         comXPos,
    input  logic [6:0]         comYPos,
    input  logic [3:0]         playerScore,
    input  logic [3:0]         comScore,
    input  logic               player_point,
    input  logic               com_point,
    input  logic               invert,
    output logic [COLOR_W-1:0] RGB_out,
    output logic               de_out
);

    localparam int CNT_W =
        ($clog2(BLINK_FRAMES) > 6) ? $clog2(BLINK_FRAMES) : 6;

    logic [7:0] sh_ball_x;
    logic [6:0] sh_ball_y;
    logic [7:0] sh_player_x;
    logic [6:0] sh_player_y;
    logic [7:0] sh_com_x;
    logic [6:0] sh_com_y;
    logic [3:0] sh_pscore;
    logic [3:0] sh_cscore;

    blink_state_t     state;
    blink_state_t     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             blank_p;
    logic             blank_c;

    logic [7:0] cx;
    logic [7:0] cy;
    logic       p_box;
    logic       c_box;
    logic [3:0] p_idx;
    logic [3:0] c_idx;
    logic       p_px;
    logic       c_px;
    hit_t       hit_c;

    logic       s1_valid;
    logic [7:0] s1_cx;
    logic [7:0] s1_cy;
    hit_t       s1_hit;

    logic               colon_hit;
    logic               net_hit;
    obj_t               obj;
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] pix;

    // Positions and scores only change at frame boundaries
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            sh_ball_x   <= '0;
            sh_ball_y   <= '0;
            sh_player_x <= '0;
            sh_player_y <= '0;
            sh_com_x    <= '0;
            sh_com_y    <= '0;
            sh_pscore   <= '0;
            sh_cscore   <= '0;
        end else if (frame_start) begin
            sh_ball_x   <= ballX;
            sh_ball_y   <= ballY;
            sh_player_x <= playerXPos;
            sh_player_y <= playerYPos;
            sh_com_x    <= comXPos;
            sh_com_y    <= comYPos;
            sh_pscore   <= playerScore;
            sh_cscore   <= comScore;
        end
    end

    // Blink state and frame counter registers
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A new point always restarts the blink; player wins a tie
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (player_point) begin
            state_nxt = BLINK_P;
            cnt_nxt   = '0;
        end else if (com_point) begin
            state_nxt = BLINK_C;
            cnt_nxt   = '0;
        end else if (frame_start && state != IDLE) begin
            if (cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // The blinking digit is hidden during odd half-periods
    always_comb begin
        blank_p = 1'b0;
        blank_c = 1'b0;
        if (((cnt / CNT_W'(BLINK_HALF)) & CNT_W'(1)) != '0) begin
            blank_p = (state == BLINK_P);
            blank_c = (state == BLINK_C);
        end
    end

    // Cell coordinates and glyph indices for the current pixel
    always_comb begin
        cx    = 8'(xCoord >> BLOCK_SHIFT);
        cy    = 8'(yCoord >> BLOCK_SHIFT);
        p_box = in_span(cx, P_DIGIT_X, DIGIT_W) &&
                in_span(cy, DIGIT_Y, DIGIT_H);
        c_box = in_span(cx, C_DIGIT_X, DIGIT_W) &&
                in_span(cy, DIGIT_Y, DIGIT_H);
        p_idx = 4'(4'(cy - DIGIT_Y) * 4'd3 + 4'(cx - P_DIGIT_X));
        c_idx = 4'(4'(cy - DIGIT_Y) * 4'd3 + 4'(cx - C_DIGIT_X));
    end

    digit_font u_pfont (
        .digit (sh_pscore),
        .idx   (p_idx),
        .pixel (p_px)
    );

    digit_font u_cfont (
        .digit (sh_cscore),
        .idx   (c_idx),
        .pixel (c_px)
    );

    // Per-object hit tests against the shadowed geometry
    always_comb begin
        hit_c.ball   = in_span(cx, sh_ball_x, 8'(BALL_SIZE)) &&
                       in_span(cy, {1'b0, sh_ball_y}, 8'(BALL_SIZE));
        hit_c.player = (cx <= sh_player_x) &&
                       in_span(cy, {1'b0, sh_player_y}, 8'(PADDLE_LEN));
        hit_c.com    = (cx >= sh_com_x) &&
                       in_span(cy, {1'b0, sh_com_y}, 8'(PADDLE_LEN));
        hit_c.pdig   = p_box && p_px && !blank_p;
        hit_c.cdig   = c_box && c_px && !blank_c;
    end

    // Stage 1: register coordinates and object hits
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            s1_valid <= 1'b0;
            s1_cx    <= '0;
            s1_cy    <= '0;
            s1_hit   <= '0;
        end else begin
            s1_valid <= de_in;
            s1_cx    <= cx;
            s1_cy    <= cy;
            s1_hit   <= hit_c;
        end
    end

    // Fixed decorations, then the highest-priority object wins
    always_comb begin
        colon_hit = (s1_cx == COLON_X) &&
                    (s1_cy == COLON_Y0 || s1_cy == COLON_Y1);
        net_hit   = (s1_cx == NET_X) && !s1_cy[2] &&
                    !(s1_cy >= NET_GAP_LO && s1_cy <= NET_GAP_HI);
        obj = OBJ_NONE;
        if (s1_hit.ball)        obj = OBJ_BALL;
        else if (s1_hit.player) obj = OBJ_PLAYER;
        else if (s1_hit.com)    obj = OBJ_COM;
        else if (s1_hit.pdig)   obj = OBJ_PDIG;
        else if (s1_hit.cdig)   obj = OBJ_CDIG;
        else if (colon_hit)     obj = OBJ_COLON;
        else if (net_hit)       obj = OBJ_NET;
        fg  = invert ? '0 : '1;
        pix = (obj != OBJ_NONE) ? fg : ~fg;
    end

    // Stage 2: colour register; invalid pixels are forced dark
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            RGB_out <= '0;
            de_out  <= 1'b0;
        end else begin
            RGB_out <= s1_valid ? pix : '0;
            de_out  <= s1_valid;
        end
    end

endmodule

// File: tb/tb_pong_renderer.sv
// Self-checking bench for pong_renderer: directed scenarios plus random
// traffic compared against a cell-level behavioural model.
module tb_pong_renderer;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       de_in;
    logic [9:0] x_coord;
    logic [9:0] y_coord;
    logic [7:0] ball_x;
    logic [6:0] ball_y;
    logic [7:0] p_x;
    logic [6:0] p_y;
    logic [7:0] c_x;
    logic [6:0] c_y;
    logic [3:0] p_score;
    logic [3:0] c_score;
    logic       p_point;
    logic       c_point;
    logic       invert;
    logic [7:0] rgb;
    logic       de_out;

    int n_chk  = 0;
    int n_pass = 0;

    int m_bx, m_by, m_px, m_py, m_cx, m_cy, m_ps, m_cs;
    int m_side;
    int m_frames;
    bit p1_v;
    bit p1_on;

    int font_rows [10][5] = '{
        '{7, 5, 5, 5, 7}, '{2, 6, 2, 2, 7}, '{7, 1, 7, 4, 7},
        '{7, 1, 7, 1, 7}, '{5, 5, 7, 1, 1}, '{7, 4, 7, 1, 7},
        '{7, 4, 7, 5, 7}, '{7, 1, 1, 1, 1}, '{7, 5, 7, 5, 7},
        '{7, 5, 7, 1, 7}
    };

    pong_renderer dut (
        .CLK_IN       (clk),
        .RST_IN       (rst),
        .frame_start  (frame_start),
        .de_in        (de_in),
        .xCoord       (x_coord),
        .yCoord       (y_coord),
        .ballX        (ball_x),
        .ballY        (ball_y),
        .playerXPos   (p_x),
        .playerYPos   (p_y),
        .comXPos      (c_x),
        .comYPos      (c_y),
        .playerScore  (p_score),
        .comScore     (c_score),
        .player_point (p_point),
        .com_point    (c_point),
        .invert       (invert),
        .RGB_out      (rgb),
        .de_out       (de_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit glyph_on(int d, int cx, int cy, int ox);
        int r, c;
        if (cx < ox || cx > ox + 2 || cy < 10 || cy > 14) return 0;
        if (d > 9) return 0;
        r = cy - 10;
        c = cx - ox;
        return ((font_rows[d][r] >> (2 - c)) & 1) == 1;
    endfunction

    function automatic bit model_on(int x, int y);
        int cx, cy;
        bit hidden, on;
        cx = (x >> 2) & 255;
        cy = (y >> 2) & 255;
        hidden = ((m_frames / 8) % 2) == 1;
        on = 0;
        if (cx >= m_bx && cx < m_bx + 4 && cy >= m_by && cy < m_by + 4)
            on = 1;
        if (cx <= m_px && cy >= m_py && cy < m_py + 32) on = 1;
        if (cx >= m_cx && cy >= m_cy && cy < m_cy + 32) on = 1;
        if (glyph_on(m_ps, cx, cy, 74) && !(m_side == 1 && hidden))
            on = 1;
        if (glyph_on(m_cs, cx, cy, 82) && !(m_side == 2 && hidden))
            on = 1;
        if (cx == 79 && (cy == 11 || cy == 13)) on = 1;
        if (cx == 80 && ((cy >> 2) & 1) == 0 && (cy < 10 || cy > 14))
            on = 1;
        return on;
    endfunction

    task automatic model_update();
        if (frame_start) begin
            m_bx = ball_x; m_by = ball_y;
            m_px = p_x;    m_py = p_y;
            m_cx = c_x;    m_cy = c_y;
            m_ps = p_score; m_cs = c_score;
        end
        if (p_point) begin
            m_side = 1; m_frames = 0;
        end else if (c_point) begin
            m_side = 2; m_frames = 0;
        end else if (frame_start && m_side != 0) begin
            m_frames++;
            if (m_frames >= 60) begin
                m_side = 0; m_frames = 0;
            end
        end
    endtask

    task automatic step();
        bit on;
        logic [7:0] exp_rgb;
        bit exp_de;
        on = model_on(int'(x_coord), int'(y_coord));
        exp_de  = rst ? 1'b0 : p1_v;
        exp_rgb = (rst || !p1_v) ? 8'h00 :
                  ((p1_on ^ invert) ? 8'hFF : 8'h00);
        @(posedge clk);
        #1;
        chk("model_rgb", rgb, exp_rgb);
        chk("model_de", de_out, exp_de);
        if (rst) begin
            p1_v = 0; p1_on = 0;
            m_bx = 0; m_by = 0; m_px = 0; m_py = 0;
            m_cx = 0; m_cy = 0; m_ps = 0; m_cs = 0;
            m_side = 0; m_frames = 0;
        end else begin
            p1_v  = de_in;
            p1_on = on;
            model_update();
        end
        frame_start = 0;
        p_point = 0;
        c_point = 0;
    endtask

    task automatic frame();
        frame_start = 1;
        step();
    endtask

    task automatic show(input string tag, input int x, input int y,
                        input logic [7:0] exp);
        x_coord = 10'(x);
        y_coord = 10'(y);
        de_in = 1;
        step();
        step();
        chk(tag, rgb, exp);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        rst = 1; frame_start = 0; de_in = 1;
        x_coord = 0; y_coord = 0;
        ball_x = 0; ball_y = 0; p_x = 0; p_y = 0;
        c_x = 0; c_y = 0; p_score = 0; c_score = 0;
        p_point = 0; c_point = 0; invert = 0;
        m_side = 0; m_frames = 0;
        p1_v = 0; p1_on = 0;

        step();
        step();
        chk("rst_rgb0", rgb, 8'h00);
        chk("rst_de0", de_out, 1'b0);
        rst = 0;
        step();
        chk("rst_rgb1", rgb, 8'h00);
        chk("rst_de1", de_out, 1'b0);
        step();
        chk("rst_de2", de_out, 1'b1);
        chk("rst_rgb2", rgb, 8'hFF);

        ball_x = 40; ball_y = 30;
        p_x = 2; p_y = 50; c_x = 150; c_y = 50;
        p_score = 8; c_score = 3;
        frame();
        show("ball_in", 160, 120, 8'hFF);
        show("ball_out", 176, 120, 8'h00);
        show("ball_right", 172, 120, 8'hFF);
        show("ball_below", 160, 136, 8'h00);

        ball_x = 60;
        show("old_pos", 160, 120, 8'hFF);
        show("new_early", 240, 120, 8'h00);
        frame();
        show("new_pos", 240, 120, 8'hFF);
        show("old_gone", 160, 120, 8'h00);

        show("colon", 316, 44, 8'hFF);
        show("net_top", 320, 0, 8'hFF);
        show("net_gap", 320, 16, 8'h00);
        show("net_lbl", 320, 40, 8'h00);
        show("com_edge", 600, 200, 8'hFF);
        show("com_out", 596, 200, 8'h00);
        show("pad_end", 0, 324, 8'hFF);
        show("pad_past", 0, 328, 8'h00);

        p_point = 1;
        step();
        for (int f = 0; f < 64; f++) begin
            show($sformatf("blink_f%0d", f), 296, 40,
                 (f < 60 && (f / 8) % 2 == 1) ? 8'h00 : 8'hFF);
            frame();
        end

        p_point = 1; c_point = 1;
        step();
        frames(8);
        show("tie_p_off", 296, 40, 8'h00);
        show("tie_c_on", 328, 40, 8'hFF);
        frames(12);
        c_point = 1;
        step();
        frames(4);
        show("swap_c_f4", 328, 40, 8'hFF);
        frames(4);
        show("swap_c_f8", 328, 40, 8'h00);
        show("swap_p_f8", 296, 40, 8'hFF);

        p_point = 1;
        step();
        frames(8);
        show("pre_rst", 296, 40, 8'h00);
        rst = 1;
        step();
        rst = 0;
        frame();
        show("rst_cancel", 296, 40, 8'hFF);

        invert = 1;
        show("inv_empty", 400, 400, 8'hFF);
        show("inv_ball", 240, 120, 8'h00);
        invert = 0;
        ball_x = 2; ball_y = 50;
        frame();
        show("overlap", 8, 200, 8'hFF);
        p_score = 12;
        frame();
        show("score12", 296, 40, 8'h00);

        for (int i = 0; i < 4000; i++) begin
            de_in   = ($urandom_range(0, 3) != 0);
            x_coord = 10'($urandom_range(0, 700));
            y_coord = 10'($urandom_range(0, 420));
            invert  = ($urandom_range(0, 7) == 0);
            ball_x  = 8'($urandom_range(0, 180));
            ball_y  = 7'($urandom_range(0, 100));
            p_x     = 8'($urandom_range(0, 20));
            p_y     = 7'($urandom_range(0, 90));
            c_x     = 8'($urandom_range(140, 255));
            c_y     = 7'($urandom_range(0, 90));
            p_score = 4'($urandom_range(0, 15));
            c_score = 4'($urandom_range(0, 15));
            frame_start = ($urandom_range(0, 9) == 0);
            p_point = ($urandom_range(0, 299) == 0);
            c_point = ($urandom_range(0, 299) == 0);
            rst     = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
